// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and bus-side signals of the shared
// memory port; slave is the arbiter's view, master is the environment's.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_ce;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_o;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_ce, dm_we, dm_sel, dm_addr, dm_wdata,
        input  bus_rdata, bus_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output stall_o, bus_err
    );

    modport master (
        output if_req, if_addr,
        output dm_ce, dm_we, dm_sel, dm_addr, dm_wdata,
        output bus_rdata, bus_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  stall_o, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus port between instruction fetch
// and MEM-stage data access, with round-robin ties and a bus timeout.
module mem_port_arbiter #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0
) (
    input logic               cpu_clk_50M,
    input logic               cpu_rst,
    mem_port_arbiter_if.slave mp
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DGNT,
        S_IGNT
    } state_t;

    state_t      r_state;
    logic        r_last_dm;
    logic        r_wd;
    logic [CW-1:0] r_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_if_rdata;
    logic        r_if_ack;
    logic [31:0] r_dm_rdata;
    logic        r_dm_ack;
    logic        r_bus_err;

    state_t      w_state;
    logic        w_last_dm;
    logic        w_wd;
    logic [CW-1:0] w_cnt;
    logic        w_bus_req;
    logic        w_bus_we;
    logic [3:0]  w_bus_sel;
    logic [31:0] w_bus_addr;
    logic [31:0] w_bus_wdata;
    logic [31:0] w_if_rdata;
    logic        w_if_ack;
    logic [31:0] w_dm_rdata;
    logic        w_dm_ack;
    logic        w_bus_err;

    logic        w_if_v;
    logic        w_dm_v;
    logic        w_pick_dm;
    logic        w_pick_if;
    logic        w_is_dm;
    logic        w_live;
    logic        w_to;
    logic [31:0] w_data;

    always_comb begin
        w_state     = r_state;
        w_last_dm   = r_last_dm;
        w_wd        = r_wd;
        w_cnt       = r_cnt;
        w_bus_req   = r_bus_req;
        w_bus_we    = r_bus_we;
        w_bus_sel   = r_bus_sel;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_if_rdata  = r_if_rdata;
        w_dm_rdata  = r_dm_rdata;
        w_if_ack    = 1'b0;
        w_dm_ack    = 1'b0;
        w_bus_err   = 1'b0;
        // a side whose ack is high right now is finished, not pending
        w_if_v    = mp.if_req & ~r_if_ack;
        w_dm_v    = mp.dm_ce & ~r_dm_ack;
        w_pick_dm = w_dm_v & (~w_if_v | ~r_last_dm);
        w_pick_if = w_if_v & ~w_pick_dm;
        w_is_dm   = (r_state == S_DGNT);
        w_live    = w_is_dm ? mp.dm_ce : mp.if_req;
        w_to      = (TIMEOUT != 0) && (r_cnt == LIM);
        w_data    = mp.bus_ack ? mp.bus_rdata : ERR_RDATA;
        unique case (r_state)
            S_IDLE: begin
                unique case (1'b1)
                    w_pick_dm: begin
                        w_state     = S_DGNT;
                        w_bus_req   = 1'b1;
                        w_bus_we    = mp.dm_we;
                        w_bus_sel   = mp.dm_sel;
                        w_bus_addr  = mp.dm_addr;
                        w_bus_wdata = mp.dm_wdata;
                        w_cnt       = '0;
                        w_wd        = 1'b0;
                    end
                    w_pick_if: begin
                        w_state     = S_IGNT;
                        w_bus_req   = 1'b1;
                        w_bus_we    = 1'b0;
                        w_bus_sel   = 4'b1111;
                        w_bus_addr  = mp.if_addr;
                        w_bus_wdata = 32'h0;
                        w_cnt       = '0;
                        w_wd        = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_DGNT, S_IGNT: begin
                if (mp.bus_ack || w_to) begin
                    w_state   = S_IDLE;
                    w_bus_req = 1'b0;
                    w_last_dm = w_is_dm;
                    w_bus_err = ~mp.bus_ack;
                    if (w_is_dm) begin
                        w_dm_rdata = w_data;
                        w_dm_ack   = w_live & ~r_wd;
                    end else begin
                        w_if_rdata = w_data;
                        w_if_ack   = w_live & ~r_wd;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                    w_wd  = r_wd | ~w_live;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state     <= S_IDLE;
            r_last_dm   <= 1'b0;
            r_wd        <= 1'b0;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_if_ack    <= 1'b0;
            r_dm_rdata  <= 32'h0;
            r_dm_ack    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_last_dm   <= w_last_dm;
            r_wd        <= w_wd;
            r_cnt       <= w_cnt;
            r_bus_req   <= w_bus_req;
            r_bus_we    <= w_bus_we;
            r_bus_sel   <= w_bus_sel;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_if_rdata  <= w_if_rdata;
            r_if_ack    <= w_if_ack;
            r_dm_rdata  <= w_dm_rdata;
            r_dm_ack    <= w_dm_ack;
            r_bus_err   <= w_bus_err;
        end
    end

    assign mp.bus_req   = r_bus_req;
    assign mp.bus_we    = r_bus_we;
    assign mp.bus_sel   = r_bus_sel;
    assign mp.bus_addr  = r_bus_addr;
    assign mp.bus_wdata = r_bus_wdata;
    assign mp.if_rdata  = r_if_rdata;
    assign mp.if_ack    = r_if_ack;
    assign mp.dm_rdata  = r_dm_rdata;
    assign mp.dm_ack    = r_dm_ack;
    assign mp.bus_err   = r_bus_err;
    assign mp.stall_o   = (mp.dm_ce & ~r_dm_ack) | (mp.if_req & ~r_if_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port
// arbiter against a transaction-level expectation.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        bit          dm;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wd;
    } txn_t;

    mem_port_arbiter_if ifa();
    mem_port_arbiter_if ift();

    mem_port_arbiter u_a (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .mp          (ifa)
    );

    mem_port_arbiter #(
        .TIMEOUT   (4),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) u_t (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .mp          (ift)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        ifa.if_req = 0; ifa.if_addr = 0; ifa.dm_ce = 0; ifa.dm_we = 0;
        ifa.dm_sel = 0; ifa.dm_addr = 0; ifa.dm_wdata = 0;
        ifa.bus_rdata = 0; ifa.bus_ack = 0;
        ift.if_req = 0; ift.if_addr = 0; ift.dm_ce = 0; ift.dm_we = 0;
        ift.dm_sel = 0; ift.dm_addr = 0; ift.dm_wdata = 0;
        ift.bus_rdata = 0; ift.bus_ack = 0;
    endtask

    task automatic wait_req();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.bus_req === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("req_seen", 32'(ok), 1);
    endtask

    task automatic serve(input int lat, input logic [31:0] rd);
        repeat (lat) tick();
        ifa.bus_ack   = 1;
        ifa.bus_rdata = rd;
        tick();
        ifa.bus_ack   = 0;
    endtask

    txn_t        q[$];
    txn_t        t;
    int          mode;
    bit          m_last_dm;
    logic [31:0] rd;
    logic [31:0] ia;
    txn_t        dt;

    initial begin
        idle_in();
        rst = 1;
        tick();
        tick();
        chk("rst_req", ifa.bus_req, 0);
        chk("rst_dack", ifa.dm_ack, 0);
        chk("rst_iack", ifa.if_ack, 0);
        chk("rst_err", ifa.bus_err, 0);
        chk("rst_addr", ifa.bus_addr, 0);
        chk("rst_stall", ifa.stall_o, 0);
        chk("rst_t_req", ift.bus_req, 0);
        rst = 0;

        // DM load alone
        ifa.dm_ce = 1; ifa.dm_we = 0; ifa.dm_sel = 4'b0011;
        ifa.dm_addr = 32'h100;
        #1;
        chk("ld_stall0", ifa.stall_o, 1);
        tick();
        chk("ld_req", ifa.bus_req, 1);
        chk("ld_addr", ifa.bus_addr, 32'h100);
        chk("ld_we", ifa.bus_we, 0);
        chk("ld_sel", ifa.bus_sel, 4'b0011);
        chk("ld_stall1", ifa.stall_o, 1);
        serve(2, 32'hA5A5_0001);
        chk("ld_ack", ifa.dm_ack, 1);
        chk("ld_rdata", ifa.dm_rdata, 32'hA5A5_0001);
        chk("ld_reqlo", ifa.bus_req, 0);
        chk("ld_stall2", ifa.stall_o, 0);
        tick();
        chk("ld_pulse", ifa.dm_ack, 0);
        chk("ld_noregrant", ifa.bus_req, 0);
        ifa.dm_ce = 0;
        tick();

        // tie after reset, then alternation
        rst = 1;
        tick();
        rst = 0;
        ifa.if_req = 1; ifa.if_addr = 32'h200;
        ifa.dm_ce = 1; ifa.dm_addr = 32'h300; ifa.dm_sel = 4'hF;
        tick();
        chk("tie1_addr", ifa.bus_addr, 32'h300);
        serve(0, 32'h3333);
        chk("tie1_dack", ifa.dm_ack, 1);
        chk("tie1_iack", ifa.if_ack, 0);
        ifa.dm_ce = 0;
        tick();
        chk("if_req", ifa.bus_req, 1);
        chk("if_addr", ifa.bus_addr, 32'h200);
        chk("if_we", ifa.bus_we, 0);
        chk("if_sel", ifa.bus_sel, 4'hF);
        chk("if_wdata", ifa.bus_wdata, 0);
        serve(1, 32'hCAFE_0200);
        chk("if_ack", ifa.if_ack, 1);
        chk("if_rdata", ifa.if_rdata, 32'hCAFE_0200);
        chk("if_dack", ifa.dm_ack, 0);
        ifa.if_req = 0;
        tick();
        ifa.if_req = 1; ifa.if_addr = 32'h204;
        ifa.dm_ce = 1; ifa.dm_addr = 32'h304;
        tick();
        chk("tie2_addr", ifa.bus_addr, 32'h304);
        serve(0, 32'h5555);
        ifa.dm_ce = 0;
        tick();
        chk("tie2_if", ifa.bus_addr, 32'h204);
        serve(0, 32'hCAFE_0204);
        chk("tie2_iack", ifa.if_ack, 1);
        ifa.if_req = 0;
        tick();

        // DM store, fields stable across wait cycles
        ifa.dm_ce = 1; ifa.dm_we = 1; ifa.dm_sel = 4'b0100;
        ifa.dm_addr = 32'h400; ifa.dm_wdata = 32'h00AB_0000;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_req", ifa.bus_req, 1);
            chk("st_we", ifa.bus_we, 1);
            chk("st_sel", ifa.bus_sel, 4'b0100);
            chk("st_addr", ifa.bus_addr, 32'h400);
            chk("st_wdata", ifa.bus_wdata, 32'h00AB_0000);
            tick();
        end
        serve(0, 32'h1234);
        chk("st_ack", ifa.dm_ack, 1);
        chk("st_iack", ifa.if_ack, 0);
        chk("st_ifrd", ifa.if_rdata, 32'hCAFE_0204);
        ifa.dm_ce = 0; ifa.dm_we = 0; ifa.dm_wdata = 0;
        tick();

        // IF withdrawal with DM pending
        ifa.if_req = 1; ifa.if_addr = 32'h500;
        tick();
        chk("wd_addr", ifa.bus_addr, 32'h500);
        ifa.if_req = 0;
        ifa.dm_ce = 1; ifa.dm_sel = 4'hF; ifa.dm_addr = 32'h600;
        tick();
        chk("wd_hold", ifa.bus_addr, 32'h500);
        serve(1, 32'h77);
        chk("wd_iack", ifa.if_ack, 0);
        chk("wd_dack", ifa.dm_ack, 0);
        chk("wd_rdata", ifa.if_rdata, 32'h77);
        chk("wd_reqlo", ifa.bus_req, 0);
        tick();
        chk("wd_dgnt", ifa.bus_req, 1);
        chk("wd_daddr", ifa.bus_addr, 32'h600);
        serve(0, 32'h66);
        chk("wd_dack2", ifa.dm_ack, 1);
        ifa.dm_ce = 0;
        tick();

        // reset while granted to DM
        ifa.dm_ce = 1; ifa.dm_addr = 32'h700;
        tick();
        chk("rs_req", ifa.bus_req, 1);
        rst = 1;
        tick();
        chk("rs_reqlo", ifa.bus_req, 0);
        chk("rs_addr", ifa.bus_addr, 0);
        chk("rs_drd", ifa.dm_rdata, 0);
        chk("rs_ird", ifa.if_rdata, 0);
        chk("rs_dack", ifa.dm_ack, 0);
        rst = 0;
        tick();
        chk("rs_regrant", ifa.bus_req, 1);
        chk("rs_raddr", ifa.bus_addr, 32'h700);
        chk("rs_nostale", ifa.dm_ack, 0);
        serve(0, 32'h7070);
        chk("rs_ack", ifa.dm_ack, 1);
        chk("rs_rdata", ifa.dm_rdata, 32'h7070);
        ifa.dm_ce = 0;
        tick();
        chk("rs_pulse", ifa.dm_ack, 0);

        // timeout with TIMEOUT=4
        ift.dm_ce = 1; ift.dm_sel = 4'hF; ift.dm_addr = 32'h10;
        tick();
        chk("to_req1", ift.bus_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", ift.bus_req, 1);
            chk("to_noerr", ift.bus_err, 0);
        end
        tick();
        chk("to_drop", ift.bus_req, 0);
        chk("to_err", ift.bus_err, 1);
        chk("to_ack", ift.dm_ack, 1);
        chk("to_rdata", ift.dm_rdata, 32'hDEAD_BEEF);
        chk("to_iack", ift.if_ack, 0);
        ift.dm_ce = 0;
        tick();
        chk("to_errpulse", ift.bus_err, 0);

        // bus_ack in the last allowed cycle wins over timeout
        ift.dm_ce = 1; ift.dm_addr = 32'h14;
        tick();
        repeat (3) tick();
        chk("la_req", ift.bus_req, 1);
        ift.bus_ack = 1; ift.bus_rdata = 32'h4444;
        tick();
        ift.bus_ack = 0;
        chk("la_err", ift.bus_err, 0);
        chk("la_ack", ift.dm_ack, 1);
        chk("la_rdata", ift.dm_rdata, 32'h4444);
        chk("la_reqlo", ift.bus_req, 0);
        ift.dm_ce = 0;
        tick();

        // IF timeout
        ift.if_req = 1; ift.if_addr = 32'h20;
        tick();
        repeat (4) tick();
        chk("ito_err", ift.bus_err, 1);
        chk("ito_ack", ift.if_ack, 1);
        chk("ito_rdata", ift.if_rdata, 32'hDEAD_BEEF);
        ift.if_req = 0;
        tick();

        // randomized rounds against a transaction-level expectation
        rst = 1;
        tick();
        rst = 0;
        m_last_dm = 0;
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 2);
            ia = $urandom;
            dt.dm = 1; dt.addr = $urandom; dt.we = 1'($urandom);
            dt.sel = 4'($urandom); dt.wd = $urandom;
            t.dm = 0; t.addr = ia; t.we = 0; t.sel = 4'hF; t.wd = 0;
            q.delete();
            if (mode == 0) q.push_back(t);
            else if (mode == 1) q.push_back(dt);
            else if (!m_last_dm) begin
                q.push_back(dt);
                q.push_back(t);
            end else begin
                q.push_back(t);
                q.push_back(dt);
            end
            if (mode != 1) begin
                ifa.if_req = 1; ifa.if_addr = ia;
            end
            if (mode != 0) begin
                ifa.dm_ce = 1; ifa.dm_we = dt.we; ifa.dm_sel = dt.sel;
                ifa.dm_addr = dt.addr; ifa.dm_wdata = dt.wd;
            end
            #1;
            chk("r_stall", ifa.stall_o, 1);
            while (q.size() > 0) begin
                t = q.pop_front();
                wait_req();
                chk("r_addr", ifa.bus_addr, t.addr);
                chk("r_we", ifa.bus_we, t.we);
                chk("r_sel", ifa.bus_sel, t.sel);
                chk("r_wdata", ifa.bus_wdata, t.wd);
                rd = $urandom;
                serve($urandom_range(0, 5), rd);
                chk("r_iack", ifa.if_ack, t.dm ? 0 : 1);
                chk("r_dack", ifa.dm_ack, t.dm ? 1 : 0);
                chk("r_rdata", t.dm ? ifa.dm_rdata : ifa.if_rdata, rd);
                if (t.dm) ifa.dm_ce = 0;
                else ifa.if_req = 0;
                m_last_dm = t.dm;
            end
            tick();
            chk("r_idle", ifa.bus_req, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
